// File: rtl/sd_dat_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sd_dat_pkg
// Description : Shared types and constants for the SD DAT transmit path:
//               FSM state encoding, CRC16 polynomial, start/stop bit levels
//               and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_dat_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        CRC       = 3'd4,
        STOP      = 3'd5
    } state_e;

    // CRC16-CCITT generator x^16 + x^12 + x^5 + 1 (x^16 term implicit)
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // SD bus framing levels
    localparam logic SD_START_BIT = 1'b0;
    localparam logic SD_STOP_BIT  = 1'b1;

    // Number of bits needed to index n distinct values (minimum 1)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reorder a buffer word so byte 0 ends up in the top byte; shifting the
    // result out MSB first then yields bytes in buffer order, MSB first.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc16
// Description : Bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line.
//               clear_i has priority over enable_i.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc16
    import sd_dat_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic feedback;

    assign feedback = bit_i ^ crc_o[15];

    // Galois-style shift: shift in one bit per enabled cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_o <= 16'h0000;
        end else if (clear_i) begin
            crc_o <= 16'h0000;
        end else if (enable_i) begin
            crc_o <= {crc_o[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_dat_tx.sv
`default_nettype none
// ============================================================================
// Module      : sd_dat_tx
// Description : SD card DAT-line block transmitter. Waits until a whole block
//               is buffered, then sends start bit, data (1-bit or 4-bit bus),
//               per-line CRC16 and stop bit, one line value per sd_tick_i.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_dat_tx
    import sd_dat_pkg::*;
#(
    parameter int MaxBlockBytes = 2048,
    parameter int LengthWidth   = idx_width(MaxBlockBytes / 4 + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sd_tick_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   wide_bus_i,
    input  logic [11:0]            block_size_i,
    input  logic [LengthWidth-1:0] fifo_length_i,
    input  logic                   fifo_empty_i,
    input  logic [31:0]            fifo_data_i,
    output logic                   fifo_pop_o,
    output logic [3:0]             dat_o,
    output logic [3:0]             dat_en_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [11:0]   block_q, block_d;
    logic          wide_q, wide_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [13:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]    dat_q, dat_d;
    logic [3:0]    en_q, en_d;
    logic          done_q, done_d;

    logic          pop;
    logic          crc_clr;
    logic          crc_en;
    logic [15:0]   crc_val [4];
    logic [3:0]    crc_bits;
    logic [3:0]    crc_sel;

    // Empty is a protocol violation checked outside; the whole block is
    // known to be buffered before the start bit goes out.
    logic          unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty_i;

    // ------------------------------------------------------------------
    // Derived datapath values
    // ------------------------------------------------------------------
    logic [3:0]    active_mask;
    logic [14:0]   bits_total;
    logic [13:0]   last_idx;
    logic [13:0]   next_idx;
    logic          word_boundary;
    logic          load_word;
    logic [31:0]   word_src;
    logic [3:0]    data_bits;
    logic [31:0]   shift_next;
    logic          block_ready;

    assign active_mask   = wide_q ? 4'hF : 4'h1;
    // Data ticks: bytes*2 nibbles or bytes*8 bits; last index fits 14 bits
    assign bits_total    = wide_q ? {2'b00, block_q, 1'b0} : {block_q, 3'b000};
    assign last_idx      = 14'(bits_total - 15'd1);
    assign next_idx      = bit_cnt_q + 14'd1;
    // A new word starts every 8 nibbles or every 32 bits
    assign word_boundary = wide_q ? (next_idx[2:0] == 3'd0) : (next_idx[4:0] == 5'd0);
    assign load_word     = (state_q == START) || ((state_q == DATA) && word_boundary);
    assign word_src      = load_word ? swap_bytes(fifo_data_i) : shreg_q;
    assign data_bits     = wide_q ? word_src[31:28] : {3'b111, word_src[31]};
    assign shift_next    = wide_q ? {word_src[27:0], 4'h0} : {word_src[30:0], 1'b0};
    assign block_ready   = 32'(fifo_length_i) >= 32'(block_q[11:2]);
    // First CRC bit is taken while leaving DATA; later ones count down
    assign crc_sel       = (state_q == DATA) ? 4'd15 : (4'd14 - bit_cnt_q[3:0]);

    // Select the current CRC bit of every line
    always_comb begin
        crc_bits = 4'h0;
        for (int l = 0; l < 4; l++) begin
            crc_bits[l] = crc_val[l][crc_sel];
        end
    end

    // Next-state, datapath and strobe logic; everything advances on ticks
    // except abort, which returns to IDLE immediately.
    always_comb begin
        state_d   = state_q;
        block_d   = block_q;
        wide_d    = wide_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        dat_d     = dat_q;
        en_d      = en_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;

        if (abort_i) begin
            state_d   = IDLE;
            dat_d     = 4'hF;
            en_d      = 4'h0;
            bit_cnt_d = 14'd0;
            crc_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    crc_clr = 1'b1;
                    dat_d   = 4'hF;
                    en_d    = 4'h0;
                    if (start_i) begin
                        block_d = block_size_i;
                        wide_d  = wide_bus_i;
                        state_d = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    crc_clr = 1'b1;
                    if (sd_tick_i && block_ready) begin
                        state_d   = START;
                        dat_d     = ({4{SD_START_BIT}} & active_mask) | ~active_mask;
                        en_d      = active_mask;
                        bit_cnt_d = 14'd0;
                    end
                end
                START: begin
                    if (sd_tick_i) begin
                        state_d   = DATA;
                        pop       = 1'b1;
                        crc_en    = 1'b1;
                        dat_d     = data_bits | ~active_mask;
                        shreg_d   = shift_next;
                        bit_cnt_d = 14'd0;
                    end
                end
                DATA: begin
                    if (sd_tick_i) begin
                        if (bit_cnt_q == last_idx) begin
                            state_d   = CRC;
                            dat_d     = crc_bits | ~active_mask;
                            bit_cnt_d = 14'd0;
                        end else begin
                            pop       = load_word;
                            crc_en    = 1'b1;
                            dat_d     = data_bits | ~active_mask;
                            shreg_d   = shift_next;
                            bit_cnt_d = next_idx;
                        end
                    end
                end
                CRC: begin
                    if (sd_tick_i) begin
                        if (bit_cnt_q[3:0] == 4'd15) begin
                            state_d   = STOP;
                            dat_d     = ({4{SD_STOP_BIT}} & active_mask) | ~active_mask;
                            bit_cnt_d = 14'd0;
                        end else begin
                            dat_d     = crc_bits | ~active_mask;
                            bit_cnt_d = next_idx;
                        end
                    end
                end
                STOP: begin
                    if (sd_tick_i) begin
                        state_d   = IDLE;
                        dat_d     = 4'hF;
                        en_d      = 4'h0;
                        done_d    = 1'b1;
                        bit_cnt_d = 14'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dat_d   = 4'hF;
                    en_d    = 4'h0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            block_q   <= 12'd0;
            wide_q    <= 1'b0;
            shreg_q   <= 32'd0;
            bit_cnt_q <= 14'd0;
            dat_q     <= 4'hF;
            en_q      <= 4'h0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            wide_q    <= wide_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dat_q     <= dat_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

    // One CRC16 per DAT line, fed with the value being driven onto it
    for (genvar g = 0; g < 4; g++) begin : g_crc
        sd_crc16 u_crc (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear_i  (crc_clr),
            .enable_i (crc_en),
            .bit_i    (dat_d[g]),
            .crc_o    (crc_val[g])
        );
    end

    assign fifo_pop_o = pop;
    assign dat_o      = dat_q;
    assign dat_en_o   = en_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_dat_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_dat_tx
// Description : Self-checking bench for sd_dat_tx with a buffer model,
//               tick generator and a scoreboard of expected line values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_dat_tx;
    import sd_dat_pkg::*;

    localparam int LW = idx_width(2048 / 4 + 1);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          sd_tick_i = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          wide_bus_i = 1'b0;
    logic [11:0]   block_size_i = 12'd0;
    logic [LW-1:0] fifo_length_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic [31:0]   fifo_data_i = 32'd0;
    logic          fifo_pop_o;
    logic [3:0]    dat_o;
    logic [3:0]    dat_en_o;
    logic          busy_o;
    logic          done_o;

    sd_dat_tx dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .sd_tick_i     (sd_tick_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .wide_bus_i    (wide_bus_i),
        .block_size_i  (block_size_i),
        .fifo_length_i (fifo_length_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_pop_o    (fifo_pop_o),
        .dat_o         (dat_o),
        .dat_en_o      (dat_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dat;
        logic [3:0] en;
    } line_t;

    typedef struct {
        bit          wide;
        int          nbytes;
        int          period;
        int          pat;
        bit          push;
        logic [15:0] crc0;
        int          exp_pops;
    } vec_t;

    line_t       exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] push_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int stream_idx = 0;
    int tick_period = 1;
    int tick_cnt = 0;
    bit flush_req = 1'b0;
    bit push_mode = 1'b0;
    bit mon_on = 1'b0;
    bit mon_started = 1'b0;
    bit mon_done = 1'b0;
    bit pop_now = 1'b0;
    bit prev_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [3:0] lv(input logic [3:0] v, input bit wide);
        return wide ? v : {3'b111, v[0]};
    endfunction

    // Buffer model, tick generator, pop/done counters and stream monitor
    initial begin
        forever begin
            @(negedge clk);
            prev_tick = sd_tick_i;
            if (pop_now) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (push_mode) fifo_q.push_back($urandom);
            end
            if (flush_req) begin
                fifo_q.delete();
                flush_req = 1'b0;
            end
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
            sd_tick_i = (tick_cnt == 0);
            tick_cnt  = (tick_cnt + 1 >= tick_period) ? 0 : tick_cnt + 1;
            fifo_length_i = LW'(fifo_q.size());
            fifo_empty_i  = (fifo_q.size() == 0);
            fifo_data_i   = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
            #1;
            pop_now = fifo_pop_o;
            if (pop_now) begin
                pop_cnt++;
                check("pop_while_empty", 32'(fifo_empty_i), 32'd0);
            end
            if (done_o) done_cnt++;
            if (mon_on && !mon_done && prev_tick) begin
                if (!mon_started && dat_en_o != 4'h0) mon_started = 1'b1;
                if (mon_started) begin
                    if (exp_q.size() == 0) begin
                        mon_done = 1'b1;
                    end else begin
                        line_t e;
                        e = exp_q.pop_front();
                        check($sformatf("stream[%0d]", stream_idx),
                              32'({dat_en_o, dat_o}), 32'({e.en, e.dat}));
                        stream_idx++;
                        if (exp_q.size() == 0) mon_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic build_expected(input bit wide, input logic [7:0] b[], input logic [15:0] crc0);
        logic [15:0] c [4];
        logic [3:0]  en;
        logic [3:0]  v;
        en = wide ? 4'hF : 4'h1;
        for (int l = 0; l < 4; l++) c[l] = 16'h0000;
        exp_q.delete();
        exp_q.push_back('{dat: lv(4'h0, wide), en: en});
        foreach (b[i]) begin
            if (!wide) begin
                for (int k = 7; k >= 0; k--) begin
                    v = {3'b000, b[i][k]};
                    exp_q.push_back('{dat: lv(v, wide), en: en});
                    c[0] = crc_upd(c[0], b[i][k]);
                end
            end else begin
                for (int h = 1; h >= 0; h--) begin
                    v = (h == 1) ? b[i][7:4] : b[i][3:0];
                    exp_q.push_back('{dat: lv(v, wide), en: en});
                    for (int l = 0; l < 4; l++) c[l] = crc_upd(c[l], v[l]);
                end
            end
        end
        if (crc0 != 16'h0000) c[0] = crc0;
        for (int k = 15; k >= 0; k--) begin
            for (int l = 0; l < 4; l++) v[l] = c[l][k];
            exp_q.push_back('{dat: lv(v, wide), en: en});
        end
        exp_q.push_back('{dat: 4'hF, en: en});
        exp_q.push_back('{dat: 4'hF, en: 4'h0});
    endtask

    task automatic make_bytes(input int nbytes, input int pat, output logic [7:0] b[]);
        b = new[nbytes];
        for (int k = 0; k < nbytes; k++) begin
            case (pat)
                0:       b[k] = 8'hFF;
                1:       b[k] = 8'(32'h12 + 32'h22 * k);
                default: b[k] = 8'($urandom);
            endcase
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] b[], input int i);
        return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    endfunction

    task automatic wait_stream(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!mon_done && cyc < budget) begin
            step();
            cyc++;
        end
        if (!mon_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: %0d stream entries left, want 0", tag, exp_q.size());
        end
        mon_on = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        int cyc;
        cyc = 0;
        while (dat_en_o == 4'h0 && cyc < 200) begin
            step();
            cyc++;
        end
        check({tag, " bus_enabled"}, 32'(dat_en_o != 4'h0), 32'd1);
    endtask

    task automatic run_block(input vec_t v, input string tag);
        logic [7:0] b[];
        int p0, d0;
        make_bytes(v.nbytes, v.pat, b);
        tick_period = v.period;
        push_mode = 1'b0;
        flush_req = 1'b1;
        step(); step();
        for (int i = 0; i < v.nbytes / 4; i++) push_q.push_back(word_of(b, i));
        build_expected(v.wide, b, v.crc0);
        step(); step();
        push_mode = v.push;
        p0 = pop_cnt;
        d0 = done_cnt;
        mon_started = 1'b0;
        mon_done = 1'b0;
        stream_idx = 0;
        mon_on = 1'b1;
        block_size_i = 12'(v.nbytes);
        wide_bus_i = v.wide;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        // A second start with different settings mid-transfer must be ignored
        block_size_i = 12'd4;
        wide_bus_i = ~v.wide;
        repeat (8) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_stream(tag, (v.nbytes * 8 + 64) * v.period + 200);
        repeat (4) step();
        push_mode = 1'b0;
        check({tag, " pops"}, 32'(pop_cnt - p0), 32'(v.exp_pops));
        check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " busy_after"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dat"}, 32'(dat_o), 32'hF);
        check({tag, " dat_en"}, 32'(dat_en_o), 32'h0);
        check({tag, " pop"}, 32'(fifo_pop_o), 32'h0);
        check({tag, " busy"}, 32'(busy_o), 32'h0);
        check({tag, " done"}, 32'(done_o), 32'h0);
    endtask

    vec_t vecs [7];

    initial begin
        logic [7:0] b[];
        int p0, d0;
        bit en_seen;

        vecs[0] = '{wide: 1'b0, nbytes: 512,  period: 1, pat: 0, push: 1'b0, crc0: 16'h7FA1, exp_pops: 128};
        vecs[1] = '{wide: 1'b1, nbytes: 4,    period: 1, pat: 1, push: 1'b0, crc0: 16'h0000, exp_pops: 1};
        vecs[2] = '{wide: 1'b1, nbytes: 64,   period: 4, pat: 2, push: 1'b1, crc0: 16'h0000, exp_pops: 16};
        vecs[3] = '{wide: 1'b0, nbytes: 32,   period: 4, pat: 2, push: 1'b1, crc0: 16'h0000, exp_pops: 8};
        vecs[4] = '{wide: 1'b1, nbytes: 2048, period: 1, pat: 2, push: 1'b0, crc0: 16'h0000, exp_pops: 512};
        vecs[5] = '{wide: 1'b0, nbytes: 2048, period: 1, pat: 1, push: 1'b0, crc0: 16'h0000, exp_pops: 512};
        vecs[6] = '{wide: 1'b1, nbytes: 8,    period: 3, pat: 2, push: 1'b0, crc0: 16'h0000, exp_pops: 2};

        // Reset values
        rst_ni = 1'b0;
        step(); step();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        step();

        // Table-driven block transfers
        foreach (vecs[i]) run_block(vecs[i], $sformatf("vec%0d", i));

        // Block waits in WAIT_DATA until all four words are buffered
        make_bytes(16, 2, b);
        tick_period = 1;
        flush_req = 1'b1;
        step(); step();
        for (int i = 0; i < 3; i++) push_q.push_back(word_of(b, i));
        build_expected(1'b0, b, 16'h0000);
        step(); step();
        p0 = pop_cnt;
        d0 = done_cnt;
        mon_started = 1'b0;
        mon_done = 1'b0;
        stream_idx = 0;
        mon_on = 1'b1;
        block_size_i = 12'd16;
        wide_bus_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        en_seen = 1'b0;
        repeat (30) begin
            step();
            if (dat_en_o != 4'h0) en_seen = 1'b1;
        end
        check("wait_data bus_enabled", 32'(en_seen), 32'd0);
        check("wait_data busy", 32'(busy_o), 32'd1);
        push_q.push_back(word_of(b, 3));
        wait_stream("wait_data", 500);
        repeat (4) step();
        check("wait_data pops", 32'(pop_cnt - p0), 32'd4);
        check("wait_data done_pulses", 32'(done_cnt - d0), 32'd1);

        // Abort at data tick 100 of a 1-bit block
        make_bytes(64, 2, b);
        tick_period = 1;
        flush_req = 1'b1;
        step(); step();
        for (int i = 0; i < 16; i++) push_q.push_back(word_of(b, i));
        step(); step();
        p0 = pop_cnt;
        d0 = done_cnt;
        block_size_i = 12'd64;
        wide_bus_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_en("abort");
        repeat (100) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort dat_en", 32'(dat_en_o), 32'h0);
        check("abort dat", 32'(dat_o), 32'hF);
        check("abort busy", 32'(busy_o), 32'h0);
        check("abort pops_before", 32'(pop_cnt - p0), 32'd4);
        p0 = pop_cnt;
        repeat (300) step();
        check("abort pops_after", 32'(pop_cnt - p0), 32'd0);
        check("abort done_pulses", 32'(done_cnt - d0), 32'd0);
        // Abort wins over a simultaneous start
        block_size_i = 12'd16;
        start_i = 1'b1;
        abort_i = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        step();
        check("abort_vs_start busy", 32'(busy_o), 32'h0);
        check("abort_vs_start dat_en", 32'(dat_en_o), 32'h0);

        // Asynchronous reset during CRC, then a clean transfer
        make_bytes(8, 2, b);
        flush_req = 1'b1;
        step(); step();
        for (int i = 0; i < 2; i++) push_q.push_back(word_of(b, i));
        step(); step();
        block_size_i = 12'd8;
        wide_bus_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_en("reset_crc");
        repeat (20) step();
        check("reset_crc pre busy", 32'(busy_o), 32'd1);
        check("reset_crc pre dat_en", 32'(dat_en_o), 32'hF);
        d0 = done_cnt;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("reset_crc async");
        step(); step(); step();
        check_reset_outputs("reset_crc held");
        rst_ni = 1'b1;
        step();
        check("reset_crc done_pulses", 32'(done_cnt - d0), 32'd0);
        run_block('{wide: 1'b1, nbytes: 16, period: 2, pat: 2, push: 1'b0, crc0: 16'h0000, exp_pops: 4},
                  "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_dat_tx.md
SD_DAT_TX -- requirements
Module: sd_dat_tx

Interface
REQ-001 SHALL have parameter MaxBlockBytes, default 2048, meaning largest block size accepted in bytes.
REQ-002 SHALL have parameter LengthWidth, default idx_width(MaxBlockBytes/4 + 1), meaning width of the FIFO fill-level input.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are listed in REQ-004 and REQ-005.
REQ-004 SHALL have port clk_i, input, 1 bit, system clock.
REQ-005 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port sd_tick_i, input, 1 bit, SD bit-period strobe (one clk_i cycle wide).
REQ-007 SHALL have port start_i, input, 1 bit, request to send one block.
REQ-008 SHALL have port abort_i, input, 1 bit, terminate the transfer.
REQ-009 SHALL have port wide_bus_i, input, 1 bit; 1 selects 4-bit mode and 0 selects 1-bit mode.
REQ-010 SHALL have port block_size_i, input, 12 bits, block size in bytes (multiple of 4, range 4..MaxBlockBytes).
REQ-011 SHALL have port fifo_length_i, input, LengthWidth bits, buffer fill level in 32-bit words.
REQ-012 SHALL have port fifo_empty_i, input, 1 bit, buffer empty flag.
REQ-013 SHALL have port fifo_data_i, input, 32 bits, buffer front word.
REQ-014 SHALL have port fifo_pop_o, output, 1 bit, one-cycle pop-front strobe.
REQ-015 SHALL have port dat_o, output, 4 bits, SD DAT line values.
REQ-016 SHALL have port dat_en_o, output, 4 bits, per-line output enable.
REQ-017 SHALL have port busy_o, output, 1 bit, high while not IDLE.
REQ-018 SHALL have port done_o, output, 1 bit, one-cycle pulse when a block completes.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_DATA, START, DATA, CRC, STOP.
REQ-020 IDLE: start_i SHALL latch block_size_i and wide_bus_i, then move to WAIT_DATA.
REQ-021 WAIT_DATA: SHALL move to START once fifo_length_i >= block_size/4 and sd_tick_i=1; the whole block is buffered before the start bit.
REQ-022 State and output updates SHALL occur only on clk_i cycles with sd_tick_i=1; each line value SHALL hold for exactly one tick period.
REQ-023 Active lines SHALL be DAT[3:0] in 4-bit mode and DAT[0] only in 1-bit mode; inactive lines SHALL have dat_en_o=0 and dat_o=1.
REQ-024 START SHALL drive 0 on active lines for one tick.
REQ-025 DATA SHALL send bytes in buffer order, byte 0 = bits [7:0] of the word.
REQ-026 DATA: each byte SHALL be sent MSB first in 1-bit mode; in 4-bit mode the high nibble SHALL be sent first, with nibble bit n on DAT[n].
REQ-027 On the tick that sends the first bit of each word, SHALL load fifo_data_i into the shift register and pulse fifo_pop_o for that one cycle.
REQ-028 SHALL NOT pop again for at least 8 ticks; this tolerates the buffer's 1–2 cycle front-update latency.
REQ-029 DATA length SHALL be block_size*8 ticks (1-bit mode) or block_size*2 ticks (4-bit mode); the bit counter is 14 bits and SHALL NOT wrap.
REQ-030 CRC SHALL send the per-line CRC16 (x^16+x^12+x^5+1, init 0, MSB first) for 16 ticks.
REQ-031 STOP SHALL drive 1 on active lines for one tick, then enter IDLE with dat_en_o=0 and pulse done_o.
REQ-032 abort_i in any state SHALL force IDLE on the next clk_i edge regardless of sd_tick_i.
REQ-033 On abort SHALL deassert dat_en_o, raise no done_o and issue no further pops; abort wins over a simultaneous start_i.
REQ-034 start_i outside IDLE SHALL be ignored.
REQ-035 fifo_empty_i=1 at a word load while in DATA is a protocol error; the bench SHALL assert that it never occurs.

Reset
REQ-036 During reset SHALL hold state IDLE and outputs dat_o=4'hF, dat_en_o=0, fifo_pop_o=0, busy_o=0, done_o=0, with all counters and CRC registers at 0.
REQ-037 Reset asserted mid-transfer SHALL immediately release the bus (dat_en_o=0) with no pop and no done pulse.

Structure
REQ-038 The state enum, the CRC16 polynomial constant and the SD start/stop bit constants SHALL reside in a shared package sd_dat_pkg.
REQ-039 The serial CRC16 SHALL be a sub-module sd_crc16 (inputs: clear, enable, bit; output: 16-bit crc), instantiated four times, one per DAT line.

Verification
REQ-040 1-bit mode, 512 bytes of 0xFF, tick every cycle -> DAT0 SHALL show 0, then 4096 ones, then CRC 0x7FA1, then 1; done_o SHALL pulse once.
REQ-041 4-bit mode, 4 bytes 0x12,0x34,0x56,0x78 (word 0x78563412) -> DAT[3:0] nibble sequence SHALL be 1,2,3,4,5,6,7,8, followed by 16 CRC ticks per line matching the reference model.
REQ-042 start_i with fifo_length_i=3 and block of 16 bytes -> SHALL stay in WAIT_DATA with dat_en_o=0 until length reaches 4, then send the start bit.
REQ-043 sd_tick_i every 4th cycle with a buffer push concurrent with each pop -> the data stream SHALL be unchanged and exactly block_size/4 pops SHALL occur.
REQ-044 abort_i asserted at data tick 100 -> next cycle state SHALL be IDLE, dat_en_o=0, no done_o, and no further fifo_pop_o.
REQ-045 rst_ni low during CRC -> outputs SHALL equal REQ-036 values asynchronously, and a new start_i after release SHALL transfer correctly.
